// File: rtl/tmu2_pkg.sv
// tmu2_pkg: constants and types shared by the TMU2 pipeline stages.
//   TMU2_DCOORD_W  signed destination coordinate width
//   TMU2_TCOORD_W  signed masked texture coordinate width (11.6 plus sign)
//   TMU2_RES_W     resolution width (pixels or texels)
//   TMU2_FRAC_BITS fractional bits of texture coordinates
package tmu2_pkg;

  localparam int TMU2_DCOORD_W  = 12;
  localparam int TMU2_TCOORD_W  = 18;
  localparam int TMU2_RES_W     = 11;
  localparam int TMU2_FRAC_BITS = 6;
  localparam int TMU2_TCLAMP_W  = TMU2_TCOORD_W - 1;

  typedef logic signed [TMU2_DCOORD_W-1:0] dcoord_t;
  typedef logic signed [TMU2_TCOORD_W-1:0] tcoord_t;
  typedef logic        [TMU2_RES_W-1:0]    res_t;
  typedef logic        [TMU2_TCLAMP_W-1:0] tclamp_t;

  // True when a destination coordinate falls outside [0, res).
  function automatic logic dcoord_outside(dcoord_t d, res_t res);
    return d[TMU2_DCOORD_W-1] | (d >= $signed({1'b0, res}));
  endfunction

endpackage

// File: rtl/tmu2_clamp_if.sv
// tmu2_clamp_if: fragment handshake and data bus around the clamp stage.
//   pipe_stb_i/pipe_ack_o with dx, dy, tx, ty     upstream (masking stage)
//   pipe_stb_o/pipe_ack_i with dx_c, dy_c, tx_c, ty_c  downstream (texel address)
//   slave  : view taken by the clamp stage
//   master : view taken by the neighbouring stages
interface tmu2_clamp_if;
  import tmu2_pkg::*;

  logic    pipe_stb_i;
  logic    pipe_ack_o;
  dcoord_t dx;
  dcoord_t dy;
  tcoord_t tx;
  tcoord_t ty;

  logic                  pipe_stb_o;
  logic                  pipe_ack_i;
  logic [TMU2_RES_W-1:0] dx_c;
  logic [TMU2_RES_W-1:0] dy_c;
  tclamp_t               tx_c;
  tclamp_t               ty_c;

  modport slave (
    input  pipe_stb_i, dx, dy, tx, ty, pipe_ack_i,
    output pipe_ack_o, pipe_stb_o, dx_c, dy_c, tx_c, ty_c
  );

  modport master (
    output pipe_stb_i, dx, dy, tx, ty, pipe_ack_i,
    input  pipe_ack_o, pipe_stb_o, dx_c, dy_c, tx_c, ty_c
  );

endinterface

// File: rtl/tmu2_clamp_axis.sv
// tmu2_clamp_axis: combinational clamp of one signed 11.6 texture coordinate
// into [0, (res-1) << FRAC_BITS]; fractional bits pass through untouched when
// the coordinate is already in range.
//   coord    in   signed masked texture coordinate
//   res      in   texture resolution along this axis (0 treated as 1 texel)
//   coord_c  out  clamped unsigned coordinate
module tmu2_clamp_axis
  import tmu2_pkg::*;
#(
  parameter int FRAC_BITS = TMU2_FRAC_BITS
) (
  input  tcoord_t coord,
  input  res_t    res,
  output tclamp_t coord_c
);

  tclamp_t max_c;

  always_comb begin
    max_c = '0;
    if (res != '0) max_c = tclamp_t'(res - 1'b1) << FRAC_BITS;
  end

  // NOTE: every path assigns coord_c, so the default-first form keeps this
  // purely combinational with no latch.
  always_comb begin
    coord_c = coord[TMU2_TCLAMP_W-1:0];
    if (coord[TMU2_TCOORD_W-1])                  coord_c = '0;
    else if (coord[TMU2_TCLAMP_W-1:0] > max_c)   coord_c = max_c;
  end

endmodule

// File: rtl/tmu2_clamp.sv
// tmu2_clamp: two-stage pipeline that drops fragments outside the destination
// frame and clamps the surviving texture coordinates to the texel range.
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   busy                 a fragment is held in either stage
//   pipe                 upstream/downstream fragment bus (slave view)
//   dst_hres, dst_vres   destination frame size (stable while busy)
//   tex_hres, tex_vres   texture size (stable while busy)
//   clr_stats            one-cycle pulse clearing drop_count
//   drop_count           saturating count of discarded fragments
module tmu2_clamp
  import tmu2_pkg::*;
#(
  parameter int FRAC_BITS = TMU2_FRAC_BITS,
  parameter int CNT_W     = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  output logic             busy,
  tmu2_clamp_if.slave      pipe,
  input  res_t             dst_hres,
  input  res_t             dst_vres,
  input  res_t             tex_hres,
  input  res_t             tex_vres,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] drop_count
);

  logic    s1_valid;
  logic    s1_drop;
  dcoord_t s1_dx;
  dcoord_t s1_dy;
  tcoord_t s1_tx;
  tcoord_t s1_ty;
  logic    s1_adv;
  logic    accept;
  tclamp_t tx_clamped;
  tclamp_t ty_clamped;

  // Dropped fragments retire without consulting the output register, so a
  // drop never waits behind a stalled downstream stage.
  assign s1_adv = s1_valid & (s1_drop | ~pipe.pipe_stb_o | pipe.pipe_ack_i);

  // Combinational path from pipe_ack_i: back-pressure reaches upstream in the
  // same cycle, which is what keeps full throughput with only two registers.
  assign pipe.pipe_ack_o = ~s1_valid | s1_adv;
  assign accept          = pipe.pipe_stb_i & pipe.pipe_ack_o;
  assign busy            = s1_valid | pipe.pipe_stb_o;

  tmu2_clamp_axis #(.FRAC_BITS(FRAC_BITS)) u_clamp_x (
    .coord   (s1_tx),
    .res     (tex_hres),
    .coord_c (tx_clamped)
  );

  tmu2_clamp_axis #(.FRAC_BITS(FRAC_BITS)) u_clamp_y (
    .coord   (s1_ty),
    .res     (tex_vres),
    .coord_c (ty_clamped)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid        <= 1'b0;
      s1_drop         <= 1'b0;
      pipe.pipe_stb_o <= 1'b0;
      drop_count      <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_drop  <= dcoord_outside(pipe.dx, dst_hres) |
                    dcoord_outside(pipe.dy, dst_vres);
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv & ~s1_drop)    pipe.pipe_stb_o <= 1'b1;
      else if (pipe.pipe_ack_i) pipe.pipe_stb_o <= 1'b0;

      // Clear has priority over a coincident drop.
      if (clr_stats)
        drop_count <= '0;
      else if (s1_adv & s1_drop & ~&drop_count)
        drop_count <= drop_count + CNT_W'(1);
    end
  end

  // NOTE: data registers are qualified by the valid flags above, so they
  // carry no reset and stay as plain enables.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      s1_dx <= pipe.dx;
      s1_dy <= pipe.dy;
      s1_tx <= pipe.tx;
      s1_ty <= pipe.ty;
    end
    if (s1_adv & ~s1_drop) begin
      pipe.dx_c <= s1_dx[TMU2_RES_W-1:0];
      pipe.dy_c <= s1_dy[TMU2_RES_W-1:0];
      pipe.tx_c <= tx_clamped;
      pipe.ty_c <= ty_clamped;
    end
  end

endmodule

// File: tb/tb_tmu2_clamp.sv
// tb_tmu2_clamp: self-checking bench for tmu2_clamp. Directed scenarios plus
// randomized streams, scored against a queue-based reference model.
module tb_tmu2_clamp;
  import tmu2_pkg::*;

  localparam int CNT_W = 16;

  logic             sys_clk   = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             busy;
  res_t             dst_hres, dst_vres, tex_hres, tex_vres;
  logic             clr_stats;
  logic [CNT_W-1:0] drop_count;

  tmu2_clamp_if bus ();

  tmu2_clamp #(.FRAC_BITS(6), .CNT_W(CNT_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .busy       (busy),
    .pipe       (bus),
    .dst_hres   (dst_hres),
    .dst_vres   (dst_vres),
    .tex_hres   (tex_hres),
    .tex_vres   (tex_vres),
    .clr_stats  (clr_stats),
    .drop_count (drop_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [10:0] dx;
    logic [10:0] dy;
    logic [16:0] tx;
    logic [16:0] ty;
  } out_t;

  int   checks    = 0;
  int   errors    = 0;
  int   out_count = 0;
  int   exp_drops = 0;
  bit   mon_en    = 1'b1;
  out_t exp_q[$];

  // Reference model: frame test and clamp straight from the arithmetic rules.
  function automatic bit model_drop(int x, int y, int hres, int vres);
    return (x < 0) || (x >= hres) || (y < 0) || (y >= vres);
  endfunction

  function automatic int model_clamp(int c, int res);
    int mx;
    mx = (res == 0) ? 0 : (res - 1) * 64;
    if (c < 0)  return 0;
    if (c > mx) return mx;
    return c;
  endfunction

  // Scoreboard: handshakes are sampled on the falling edge, i.e. the values
  // that the next rising edge will act on.
  always @(negedge sys_clk) begin
    if (sys_rst_n && mon_en) begin
      if (bus.pipe_stb_o && bus.pipe_ack_i) begin
        checks++;
        out_count++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output dx_c=%0d dy_c=%0d tx_c=%h (no fragment expected)",
                   bus.dx_c, bus.dy_c, bus.tx_c);
        end else begin
          out_t e;
          e = exp_q.pop_front();
          if ({bus.dx_c, bus.dy_c, bus.tx_c, bus.ty_c} !== {e.dx, e.dy, e.tx, e.ty}) begin
            errors++;
            $display("FAIL output_data got dx=%0d dy=%0d tx=%h ty=%h expected dx=%0d dy=%0d tx=%h ty=%h",
                     bus.dx_c, bus.dy_c, bus.tx_c, bus.ty_c, e.dx, e.dy, e.tx, e.ty);
          end
        end
      end
      if (bus.pipe_stb_i && bus.pipe_ack_o) begin
        if (model_drop(int'(bus.dx), int'(bus.dy), int'(dst_hres), int'(dst_vres))) begin
          if (exp_drops < 65535) exp_drops++;
        end else begin
          out_t e;
          e.dx = 11'(int'(bus.dx));
          e.dy = 11'(int'(bus.dy));
          e.tx = 17'(model_clamp(int'(bus.tx), int'(tex_hres)));
          e.ty = 17'(model_clamp(int'(bus.ty), int'(tex_vres)));
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic do_reset();
    sys_rst_n      = 1'b0;
    bus.pipe_stb_i = 1'b0;
    bus.pipe_ack_i = 1'b1;
    clr_stats      = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    exp_q.delete();
    exp_drops = 0;
    sys_rst_n = 1'b1;
  endtask

  task automatic sync();
    @(posedge sys_clk);
    #1;
  endtask

  // Drive one fragment (call just after a rising edge); returns just after
  // the accepting edge so consecutive calls stream without bubbles.
  task automatic send(input int x, input int y, input int u, input int v);
    bit ok;
    ok = 1'b0;
    bus.pipe_stb_i = 1'b1;
    bus.dx = 12'(x);
    bus.dy = 12'(y);
    bus.tx = 18'(u);
    bus.ty = 18'(v);
    for (int n = 0; n < 200; n++) begin
      @(negedge sys_clk);
      if (bus.pipe_ack_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout ack_o=%b required 1 within 200 cycles", bus.pipe_ack_o);
    end
    @(posedge sys_clk);
    #1;
    bus.pipe_stb_i = 1'b0;
  endtask

  task automatic wait_stb(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge sys_clk);
      if (bus.pipe_stb_o) begin
        ok = 1'b1;
        return;
      end
    end
    errors++;
    $display("FAIL wait_stb_timeout stb_o=0 required 1 within 50 cycles");
  endtask

  task automatic drain();
    bus.pipe_ack_i = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge sys_clk);
      if (!busy) return;
    end
    errors++;
    $display("FAIL drain_timeout busy=%b required 0 within 100 cycles", busy);
  endtask

  task automatic test_reset();
    dst_hres = 11'd640; dst_vres = 11'd480;
    tex_hres = 11'd512; tex_vres = 11'd512;
    bus.dx = '0; bus.dy = '0; bus.tx = '0; bus.ty = '0;
    do_reset();
    @(negedge sys_clk);
    checks++;
    if ({bus.pipe_stb_o, busy, bus.pipe_ack_o} !== 3'b001) begin
      errors++;
      $display("FAIL reset_flags stb_o=%b busy=%b ack_o=%b required 0 0 1",
               bus.pipe_stb_o, busy, bus.pipe_ack_o);
    end
    checks++;
    if (drop_count !== '0) begin
      errors++;
      $display("FAIL reset_drop_count got %h required 0", drop_count);
    end
  endtask

  task automatic test_basic();
    sync();
    send(5, 7, 'h00140, 'h00080);
    @(negedge sys_clk);
    checks++;
    if (bus.pipe_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early stb_o=%b required 0 one cycle after accept", bus.pipe_stb_o);
    end
    @(negedge sys_clk);
    checks++;
    if ({bus.pipe_stb_o, bus.dx_c, bus.dy_c, bus.tx_c, bus.ty_c} !==
        {1'b1, 11'd5, 11'd7, 17'h00140, 17'h00080}) begin
      errors++;
      $display("FAIL basic_output stb_o=%b dx=%0d dy=%0d tx=%h ty=%h required 1 5 7 00140 00080",
               bus.pipe_stb_o, bus.dx_c, bus.dy_c, bus.tx_c, bus.ty_c);
    end
    checks++;
    if (drop_count !== '0) begin
      errors++;
      $display("FAIL basic_drop_count got %h required 0", drop_count);
    end
    drain();
  endtask

  task automatic test_clamp();
    bit ok;
    sync();
    send(10, 20, -64, 'h10000);
    wait_stb(ok);
    checks++;
    if (!ok || bus.tx_c !== 17'h0 || bus.ty_c !== 17'h07FC0) begin
      errors++;
      $display("FAIL clamp_limits tx=%h ty=%h required 00000 07fc0", bus.tx_c, bus.ty_c);
    end
    sync();
    send(11, 21, 'h00145, 'h1FFFF);
    wait_stb(ok);
    checks++;
    if (!ok || bus.tx_c !== 17'h00145 || bus.ty_c !== 17'h07FC0) begin
      errors++;
      $display("FAIL clamp_fraction tx=%h ty=%h required 00145 07fc0", bus.tx_c, bus.ty_c);
    end
    drain();
  endtask

  task automatic test_drop();
    do_reset();
    sync();
    send(640, 10, 0, 0);
    send(10, -1, 0, 0);
    send(3, 4, 'h40, 'h80);
    @(negedge sys_clk);
    checks++;
    if (bus.pipe_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_stb stb_o=%b required 0", bus.pipe_stb_o);
    end
    @(negedge sys_clk);
    checks++;
    if (bus.pipe_stb_o !== 1'b1 || bus.dx_c !== 11'd3 || bus.dy_c !== 11'd4) begin
      errors++;
      $display("FAIL drop_no_bubble stb_o=%b dx=%0d dy=%0d required 1 3 4",
               bus.pipe_stb_o, bus.dx_c, bus.dy_c);
    end
    drain();
    checks++;
    if (drop_count !== 16'd2) begin
      errors++;
      $display("FAIL drop_count got %0d required 2", drop_count);
    end
  endtask

  task automatic test_back_to_back();
    int          start;
    logic [10:0] cap_dx;
    logic [16:0] cap_tx;
    start = out_count;
    bus.pipe_ack_i = 1'b1;
    sync();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(i + 1, i + 2, i * 64 + i, i * 128 + 3);
      end
      begin
        repeat (3) @(posedge sys_clk);
        #1;
        bus.pipe_ack_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge sys_clk);
          if (k == 0) begin
            cap_dx = bus.dx_c;
            cap_tx = bus.tx_c;
          end else begin
            checks++;
            if (bus.dx_c !== cap_dx || bus.tx_c !== cap_tx) begin
              errors++;
              $display("FAIL stall_hold dx=%0d tx=%h required %0d %h", bus.dx_c, bus.tx_c, cap_dx, cap_tx);
            end
          end
          checks++;
          if (bus.pipe_ack_o !== 1'b0 || bus.pipe_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_backpressure ack_o=%b stb_o=%b required 0 1",
                     bus.pipe_ack_o, bus.pipe_stb_o);
          end
        end
        @(posedge sys_clk);
        #1;
        bus.pipe_ack_i = 1'b1;
      end
    join
    drain();
    checks++;
    if (out_count - start != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_delivery delivered=%0d pending=%0d required 8 0", out_count - start, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    sync();
    for (int i = 0; i < 65536; i++) send(-1, 0, 0, 0);
    drain();
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold got %h required ffff", drop_count);
    end
    sync();
    clr_stats = 1'b1;
    sync();
    clr_stats = 1'b0;
    exp_drops = 0;
    checks++;
    if (drop_count !== '0) begin
      errors++;
      $display("FAIL sat_clear got %h required 0", drop_count);
    end
    send(5, 2000, 0, 0);
    drain();
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL sat_after_clear got %h required 1", drop_count);
    end
    sync();
    send(-5, 0, 0, 0);
    clr_stats = 1'b1;
    sync();
    clr_stats = 1'b0;
    exp_drops = 0;
    @(negedge sys_clk);
    checks++;
    if (drop_count !== '0) begin
      errors++;
      $display("FAIL clear_wins got %h required 0", drop_count);
    end
  endtask

  task automatic test_async_reset();
    bus.pipe_ack_i = 1'b0;
    sync();
    send(1, 1, 64, 64);
    send(2, 2, 128, 128);
    #2;
    mon_en    = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.pipe_stb_o, busy, drop_count} !== {1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL async_reset stb_o=%b busy=%b drop_count=%h required 0 0 0",
               bus.pipe_stb_o, busy, drop_count);
    end
    sync();
    exp_q.delete();
    exp_drops      = 0;
    sys_rst_n      = 1'b1;
    mon_en         = 1'b1;
    bus.pipe_ack_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge sys_clk);
      checks++;
      if (bus.pipe_stb_o !== 1'b0) begin
        errors++;
        $display("FAIL async_stale stb_o=%b required 0 at cycle %0d", bus.pipe_stb_o, n);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      bit done;
      int h, v, th, tv;
      do_reset();
      h  = (r == 2) ? 0 : int'($urandom_range(1, 700));
      v  = int'($urandom_range(1, 700));
      th = (r == 1) ? 0 : int'($urandom_range(1, 1024));
      tv = int'($urandom_range(0, 1024));
      dst_hres = 11'(h); dst_vres = 11'(v);
      tex_hres = 11'(th); tex_vres = 11'(tv);
      done = 1'b0;
      sync();
      fork
        begin
          for (int i = 0; i < 300; i++)
            send(int'($urandom_range(0, 2 * h + 20)) - 10,
                 int'($urandom_range(0, 2 * v + 20)) - 10,
                 int'($urandom_range(0, th * 64 + 4000)) - 2000,
                 int'($urandom_range(0, tv * 64 + 4000)) - 2000);
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge sys_clk);
            #1;
            bus.pipe_ack_i = 1'($urandom_range(0, 1));
          end
        end
      join
      drain();
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL random_pending round %0d got %0d outstanding required 0", r, exp_q.size());
      end
      checks++;
      if (int'(drop_count) != exp_drops) begin
        errors++;
        $display("FAIL random_drop_count round %0d got %0d required %0d", r, drop_count, exp_drops);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_drop();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmu2_clamp.md
Name: tmu2_clamp

Overview:
- Pipeline stage directly downstream of the texture-coordinate masking stage in the TMU2 texture-mapping pipeline.
- Discards fragments whose destination point (dx, dy) lies outside the destination frame.
- Clamps the surviving masked texture coordinates (tx, ty) to the valid texel range and emits unsigned coordinates to the texel-address stage.
- Two-stage registered pipeline: one fragment per cycle throughput, stb/ack handshake on both sides, saturating drop counter for statistics.

Parameters:
- FRAC_BITS, 6, fractional bits of tx/ty (fixed-point 11.6).
- CNT_W, 16, width of the dropped-fragment counter.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- busy  out  1  any fragment held in the block
- pipe_stb_i  in  1  upstream fragment valid
- pipe_ack_o  out  1  block accepts the upstream fragment
- dx  in  12  signed destination X
- dy  in  12  signed destination Y
- tx  in  18  signed masked texture X, 11.6
- ty  in  18  signed masked texture Y, 11.6
- dst_hres  in  11  destination width in pixels
- dst_vres  in  11  destination height in pixels
- tex_hres  in  11  texture width in texels
- tex_vres  in  11  texture height in texels
- clr_stats  in  1  single-cycle pulse that clears drop_count
- pipe_stb_o  out  1  downstream fragment valid
- pipe_ack_i  in  1  downstream accepts
- dx_c  out  11  unsigned destination X
- dy_c  out  11  unsigned destination Y
- tx_c  out  17  clamped texture X, unsigned 11.6
- ty_c  out  17  clamped texture Y, unsigned 11.6
- drop_count  out  CNT_W  fragments discarded since reset or clear

Behaviour:

Reset (asynchronous, sys_rst_n low):
- s1_valid = 0, pipe_stb_o = 0, drop_count = 0.
- Data registers are don't-care.
- Reset asserted mid-operation discards all in-flight fragments immediately.

Stage 1 (accept):
- pipe_ack_o = ~s1_valid | s1_adv.
- On pipe_stb_i & pipe_ack_o: register dx/dy/tx/ty, set s1_valid = 1, and register s1_drop = (dx<0) | (dx >= {0,dst_hres}) | (dy<0) | (dy >= {0,dst_vres}).
- If s1_adv occurs with no new accept, s1_valid clears.

Stage 2 (advance):
- s1_adv = s1_valid & (s1_drop | ~pipe_stb_o | pipe_ack_i).
- Dropped fragments never wait on the downstream stage.
- On s1_adv & ~s1_drop:
  - pipe_stb_o <= 1
  - dx_c <= dx[10:0], dy_c <= dy[10:0]
  - tx_c <= clamp(tx, tex_hres), ty_c <= clamp(ty, tex_vres)
- On s1_adv & s1_drop: pipe_stb_o <= 0 if pipe_ack_i, otherwise it holds; drop_count increments.
- pipe_stb_o clears on pipe_ack_i when no new fragment is loaded.
- Output data is stable while pipe_stb_o & ~pipe_ack_i.

Clamp rule:
- max = (res==0 ? 0 : res-1) << FRAC_BITS, 17 bits.
- Coordinate < 0 → 0; coordinate > max → max; otherwise coordinate[16:0].
- The fractional part is preserved when no clamp occurs.

Drop counter:
- Saturates at all-ones.
- clr_stats in the same cycle as a drop → 0 (clear wins).

Latency and throughput:
- Accept to pipe_stb_o: 2 cycles.
- Full throughput when pipe_ack_i is held high.
- Back-pressure propagates back to pipe_ack_o in the same cycle.

Misc:
- busy = s1_valid | pipe_stb_o.
- dst_*/tex_* must be stable while busy; changing them mid-flight gives undefined results for in-flight fragments only.
- dst_hres = 0 or dst_vres = 0 → every fragment is dropped.

Decomposition:
- Shared package tmu2_pkg: constants TMU2_DCOORD_W=12, TMU2_TCOORD_W=18, TMU2_RES_W=11, TMU2_FRAC_BITS=6.
- Sub-module tmu2_clamp_axis: combinational clamp of one signed coordinate against one resolution. Instantiated twice (X and Y).

Test Plan:
1. Reset, then dx=5, dy=7, tx=0x00140 (5.0), ty=0x00080, res 640x480 / tex 512x512, ack_i=1 → exactly 2 cycles later stb_o=1, dx_c=5, dy_c=7, tx_c=0x00140, ty_c=0x00080; drop_count=0.
2. tx=-64, ty=0x10000 (1024.0), tex 512x512 → tx_c=0, ty_c=511<<6=0x07FC0; fractional bits preserved for an in-range tx=0x00145.
3. dx=640 with dst_hres=640, then dy=-1 → no stb_o for either, drop_count=2; a following valid fragment emerges without a bubble caused by the drops.
4. Stream of 8 fragments with ack_i low for cycles 3–6 → ack_o drops within the same cycle once both stages are full; stb_o and data held; all 8 delivered in order with no loss or duplication.
5. drop_count at 0xFFFF plus another drop → stays 0xFFFF; clr_stats coinciding with a drop → 0.
6. sys_rst_n pulsed low while both stages hold fragments → stb_o=0 and busy=0 immediately (asynchronous); no stale fragment is emitted after release.
